// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y raster counters,
// registered sync pulses, visible-area flag and a once-per-frame refresh tick.
module vga_sync_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_DISP   = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_DISP   = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISP);
   localparam logic [9:0] V_VIS    = 10'(V_DISP);
   localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);
   localparam logic [9:0] FT_LINE  = 10'(V_DISP + 1);

   logic [DW-1:0] div;
   logic [9:0]    x_next;
   logic [9:0]    y_next;

   // p_tick is registered from the divider, so the first tick lands two
   // clocks after release and CLK_DIV=1 still reads 0 while in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div    <= '0;
         p_tick <= 1'b0;
      end else begin
         div    <= (div == DIV_MAX) ? '0 : div + 1'b1;
         p_tick <= (div == DIV_MAX);
      end
   end

   always_comb begin
      x_next = pix_x;
      y_next = pix_y;
      if (p_tick) begin
         if (pix_x == H_MAX) begin
            x_next = '0;
            y_next = (pix_y == V_MAX) ? '0 : pix_y + 10'd1;
         end else begin
            x_next = pix_x + 10'd1;
         end
      end
   end

   // Syncs decode the next count so they switch on the same edge as the counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_x <= '0;
         pix_y <= '0;
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
      end else begin
         pix_x <= x_next;
         pix_y <= y_next;
         hsync <= (x_next >= HS_FIRST && x_next <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
         vsync <= (y_next >= VS_FIRST && y_next <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign video_on   = (pix_x < H_VIS) && (pix_y < V_VIS);
   assign frame_tick = p_tick && (pix_x == 10'd0) && (pix_y == FT_LINE);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a shrunken-raster
// instance, both checked every cycle against an arithmetic raster model.
module tb_vga_sync_gen;

   typedef struct {
      int div, hd, hf, hs, hb, vd, vf, vs, vb;
      bit pol;
   } tm_t;

   typedef struct {
      int k;
      int x, y;
      bit hs, vs, von, pt;
   } vec_t;

   localparam tm_t TD = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
   localparam tm_t TS = '{3, 10, 2, 3, 2, 6, 1, 2, 2, 1'b1};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic hs_d, vs_d, von_d, pt_d, ft_d;
   logic hs_s, vs_s, von_s, pt_s, ft_s;
   logic [9:0] x_d, y_d, x_s, y_s;

   int total = 0;
   int bad = 0;
   int k = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .clk(clk), .reset(reset), .hsync(hs_d), .vsync(vs_d), .video_on(von_d),
      .p_tick(pt_d), .pix_x(x_d), .pix_y(y_d), .frame_tick(ft_d)
   );

   vga_sync_gen #(
      .CLK_DIV(TS.div), .H_DISP(TS.hd), .H_FP(TS.hf), .H_SYNC(TS.hs), .H_BP(TS.hb),
      .V_DISP(TS.vd), .V_FP(TS.vf), .V_SYNC(TS.vs), .V_BP(TS.vb), .SYNC_POL(TS.pol)
   ) dut_s (
      .clk(clk), .reset(reset), .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
      .p_tick(pt_s), .pix_x(x_s), .pix_y(y_s), .frame_tick(ft_s)
   );

   // Raster position after k clock edges since reset release, as plain arithmetic.
   function automatic logic [24:0] model(input tm_t t, input int kk);
      int ht, vt, p, x, y;
      bit pt, hs, vs, von, ft;
      ht  = t.hd + t.hf + t.hs + t.hb;
      vt  = t.vd + t.vf + t.vs + t.vb;
      pt  = (kk > 0) && (kk % t.div == 0);
      p   = (kk > 0) ? (kk - 1) / t.div : 0;
      x   = p % ht;
      y   = (p / ht) % vt;
      hs  = (x >= t.hd + t.hf && x < t.hd + t.hf + t.hs) ? t.pol : ~t.pol;
      vs  = (y >= t.vd + t.vf && y < t.vd + t.vf + t.vs) ? t.pol : ~t.pol;
      von = (x < t.hd) && (y < t.vd);
      ft  = pt && (x == 0) && (y == t.vd + 1);
      return {hs, vs, von, pt, ft, 10'(x), 10'(y)};
   endfunction

   function automatic logic [24:0] pack_d();
      return {hs_d, vs_d, von_d, pt_d, ft_d, x_d, y_d};
   endfunction

   function automatic logic [24:0] pack_s();
      return {hs_s, vs_s, von_s, pt_s, ft_s, x_s, y_s};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or posedge reset)
      if (reset) k <= 0;
      else       k <= k + 1;

   always @(negedge clk)
      if (mon_en) begin
         chk("mon_default", 32'(pack_d()), 32'(model(TD, k)));
         chk("mon_small", 32'(pack_s()), 32'(model(TS, k)));
      end

   task automatic do_reset(input int n);
      @(posedge clk); #1 reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   vec_t vt[12];
   int n_ft, n_pt, n_von, n_vs, last_ft, found, lo_clk, lo_pt, x_fall, x_rise;
   bit prev_hs;

   initial begin
      vt[0]  = '{0,    0,   0, 1, 1, 1, 0};
      vt[1]  = '{1,    0,   0, 1, 1, 1, 0};
      vt[2]  = '{2,    0,   0, 1, 1, 1, 1};
      vt[3]  = '{3,    1,   0, 1, 1, 1, 0};
      vt[4]  = '{1281, 640, 0, 1, 1, 0, 0};
      vt[5]  = '{1312, 655, 0, 1, 1, 0, 1};
      vt[6]  = '{1313, 656, 0, 0, 1, 0, 0};
      vt[7]  = '{1503, 751, 0, 0, 1, 0, 0};
      vt[8]  = '{1505, 752, 0, 1, 1, 0, 0};
      vt[9]  = '{1599, 799, 0, 1, 1, 0, 0};
      vt[10] = '{1600, 799, 0, 1, 1, 0, 1};
      vt[11] = '{1601, 0,   1, 1, 1, 1, 0};

      @(posedge clk); #1;
      mon_en = 1'b1;

      // Reset held 5 clk: outputs sit at their reset values throughout.
      repeat (4) begin
         @(negedge clk);
         chk("rst_hold", 32'(pack_d()), {7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0});
      end

      foreach (vt[i]) begin
         do_reset(5);
         repeat (vt[i].k) @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d", i), 32'(pack_d()),
             {7'd0, vt[i].hs, vt[i].vs, vt[i].von, vt[i].pt, 1'b0, 10'(vt[i].x), 10'(vt[i].y)});
      end

      // hsync pulse on one full line of the default raster.
      do_reset(2);
      lo_clk = 0; lo_pt = 0; x_fall = -1; x_rise = -1; prev_hs = 1'b1;
      repeat (1700) begin
         @(negedge clk);
         if (!hs_d) begin
            lo_clk++;
            if (pt_d) lo_pt++;
         end
         if (prev_hs && !hs_d) x_fall = int'(x_d);
         if (!prev_hs && hs_d) x_rise = int'(x_d);
         prev_hs = hs_d;
      end
      chk("hs_low_clk", 32'(lo_clk), 32'd192);
      chk("hs_low_ptick", 32'(lo_pt), 32'd96);
      chk("hs_fall_x", 32'(x_fall), 32'd656);
      chk("hs_rise_x", 32'(x_rise), 32'd752);

      // Three frames of the small raster: frame ticks, visible and vsync p_ticks.
      do_reset(2);
      n_ft = 0; n_pt = 0; n_von = 0; n_vs = 0; last_ft = -1;
      repeat (3 * 561) begin
         @(negedge clk);
         if (pt_s) begin
            if (von_s) n_von++;
            if (vs_s == TS.pol) n_vs++;
         end
         if (ft_s) begin
            n_ft++;
            chk("ft_pos", {x_s, y_s}, {10'd0, 10'd7});
            chk("ft_quiet_video", 32'(von_s), 32'd0);
            if (last_ft >= 0) chk("ft_spacing", 32'(n_pt - last_ft), 32'd187);
            last_ft = n_pt;
         end
         if (pt_s) n_pt++;
      end
      chk("ft_count", 32'(n_ft), 32'd3);
      chk("von_ptick", 32'(n_von), 32'd180);
      chk("vs_ptick", 32'(n_vs), 32'd102);

      // Mid-frame async reset at (5,3) of the small raster, held one clock.
      do_reset(2);
      found = 0;
      for (int c = 0; c < 2000 && found == 0; c++) begin
         @(negedge clk);
         if (x_s == 10'd5 && y_s == 10'd3) found = 1;
      end
      chk("midrst_reach", 32'(found), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("midrst_small", 32'(pack_s()), 32'(model(TS, 0)));
      chk("midrst_default", 32'(pack_d()), 32'(model(TD, 0)));
      @(posedge clk); #1 reset = 1'b0;
      repeat (400) @(negedge clk);

      // Random run lengths and reset pulses, some landing in the low clock phase.
      for (int it = 0; it < 12; it++) begin
         repeat ($urandom_range(2500, 50)) @(posedge clk);
         if ($urandom_range(1, 0) == 1) begin
            @(negedge clk); #3 reset = 1'b1;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1 reset = 1'b0;
         end else begin
            do_reset($urandom_range(3, 1));
         end
      end
      repeat (50) @(posedge clk);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
